// File: rtl/ram_param.sv
// Single-port parameterised RAM that clears itself to zero after reset.
// Reads are registered (1-cycle latency). WRITE_FIRST picks what a same-cycle read returns.
module ram_param #(
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 14,
    parameter int WRITE_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] add,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [WIDTH-1:0]  out_q;
    logic              out_valid_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic              rd_acc;
    logic [WIDTH-1:0]  rd_data;

    assign cnt_d   = cnt_q + 1'b1;
    assign rd_acc  = (state_q == READY) && en && read;
    assign rd_data = ((WRITE_FIRST != 0) && write) ? in : mem[add];

    // The clear sweep and user writes share the one write port.
    // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = add;
        mem_wd = in;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
            end else if (en && write) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset branch; the clear sweep zeroes it so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // NOTE: state is updated with <= so every register sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                out_q <= rd_data;
            end
            case (state_q)
                CLEAR: begin
                    if (cnt_q == '1) begin
                        state_q <= READY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: read-first and write-first instances share one stimulus stream.
// A word-array model predicts read data into per-instance queues that a monitor drains.
module tb_ram_param;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] add;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  out0, out1;
    logic              ov0, ov1;
    logic              busy0, busy1;

    always #5 clk = ~clk;

    ram_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WRITE_FIRST(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .read(read), .write(write),
        .add(add), .in(din), .out(out0), .out_valid(ov0), .busy(busy0)
    );

    ram_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WRITE_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .read(read), .write(write),
        .add(add), .in(din), .out(out1), .out_valid(ov1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: word array, remaining clear edges, last read value per instance.
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               clear_left = DEPTH;
    logic [WIDTH-1:0] out_m0, out_m1;
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    bit               mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus, with model update and per-edge checks afterward.
    task automatic cycle(input logic r, input logic e, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        logic exp_valid;
        @(negedge clk);
        reset = r; en = e; read = rd; write = wr; add = a; din = d;
        exp_valid = 1'b0;
        if (r) begin
            clear_left = DEPTH;
            out_m0 = '0;
            out_m1 = '0;
        end else if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
        end else if (e) begin
            if (rd) begin
                exp_valid = 1'b1;
                out_m0 = mem_m[a];
                out_m1 = wr ? d : mem_m[a];
                q0.push_back(out_m0);
                q1.push_back(out_m1);
            end
            if (wr) mem_m[a] = d;
        end
        @(posedge clk);
        #1;
        check("busy0", busy0, clear_left > 0);
        check("busy1", busy1, clear_left > 0);
        check("valid0", ov0, exp_valid);
        check("valid1", ov1, exp_valid);
        check("out_hold0", out0, out_m0);
        check("out_hold1", out1, out_m1);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    // Issues requests during the clear and counts edges until busy drops.
    task automatic count_clear(input string name);
        int n = 0;
        do begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), 16'hFFFF);
            n++;
        end while (busy0 && n < 20);
        check(name, n, DEPTH);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (ov0) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected", 1, 0);
                end else begin
                    check("sb_data0", out0, q0.pop_front());
                end
            end
            if (ov1) begin
                if (q1.size() == 0) begin
                    check("sb1_unexpected", 1, 0);
                end else begin
                    check("sb_data1", out1, q1.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; read = 1'b0; write = 1'b0; add = '0; din = '0;
        out_m0 = '0; out_m1 = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        // Reset edge, then the clear sweep with requests gated by busy.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        mon_en = 1'b1;
        check("reset_out0", out0, 16'h0000);
        count_clear("clear_edges");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, ADDR_W'(i), '0);

        // Write then read, then two idle edges with out held.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 16'hA5A5);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, '0);
        check("rd5_out0", out0, 16'hA5A5);
        idle();
        idle();
        check("rd5_hold0", out0, 16'hA5A5);

        // Same-cycle read and write at address 2, then a plain read.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h1111);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h2222);
        check("rw_first0", out0, 16'h1111);
        check("rw_first1", out1, 16'h2222);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, '0);
        check("rw_after0", out0, 16'h2222);

        // Chip select low: write and read ignored.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'hFFFF);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, '0);
        check("gated_en0", out0, 16'h0000);

        // Back-to-back stream.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, ADDR_W'(i), 16'(i * 16'h0101));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, ADDR_W'(i), '0);

        // Reset in the middle of the clear restarts it from address 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        count_clear("midclear_edges");

        // Reset during operation wipes stored data.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 16'hBEEF);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, '0);
        check("midop_out0", out0, 16'h0000);
        count_clear("midop_clear_edges");
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, '0);
        check("midop_rd7", out0, 16'h0000);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 60) == 0), $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), ADDR_W'($urandom), 16'($urandom));
        end

        idle();
        idle();
        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 14, the address width; DEPTH = 2^ADDR_W words.
REQ-003 The block SHALL have parameter WRITE_FIRST, default 0, selecting same-cycle read/write behaviour (0 = read-first, 1 = write-first).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: chip select; when low, read and write are ignored.
REQ-007 The block SHALL have port read, input, 1 bit: read request.
REQ-008 The block SHALL have port write, input, 1 bit: write request.
REQ-009 The block SHALL have port add, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port in, input, WIDTH bits: write data.
REQ-011 The block SHALL have port out, output, WIDTH bits: registered read data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking new data on out.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the memory is being cleared; requests are ignored while it is high.

Function
REQ-014 Storage SHALL be DEPTH words of WIDTH bits, inferred as an array.
REQ-015 The FSM SHALL have two states: CLEAR and READY.
REQ-016 In CLEAR, a clear counter SHALL write 0 to address cnt on each edge, then increment cnt.
REQ-017 The FSM SHALL go from CLEAR to READY on the edge that writes address DEPTH-1; the counter SHALL NOT wrap or continue.
REQ-018 busy SHALL be 1 exactly while the state is CLEAR.
REQ-019 A write SHALL be accepted on an edge where en=1, write=1 and busy=0, storing mem[add] <= in.
REQ-020 A read SHALL be accepted on an edge where en=1, read=1 and busy=0; out <= mem[add] and out_valid <= 1 on that edge, giving 1-cycle latency.
REQ-021 On every edge without an accepted read, out_valid SHALL be 0 and out SHALL hold its previous value (never X or Z).
REQ-022 On a simultaneous accepted read and write, the write SHALL always complete; out SHALL receive the old mem[add] when WRITE_FIRST=0, and the new value in when WRITE_FIRST=1.
REQ-023 Requests presented while busy=1 or en=0 SHALL have no effect on memory, out or out_valid.
REQ-024 With read=0 and write=0 and en=1, nothing SHALL change except out_valid, which goes to 0.

Reset
REQ-025 On any edge with reset=1, the block SHALL set state=CLEAR, cnt=0, out=0, out_valid=0 and busy=1; no memory write occurs on that edge.
REQ-026 Reset asserted mid-clear or in READY SHALL restart clearing from address 0 on the first edge with reset=0.
REQ-027 After reset deasserts, edges 1..DEPTH SHALL clear addresses 0..DEPTH-1; busy=0 after edge DEPTH, and the first request can be accepted at edge DEPTH+1.
REQ-028 Memory contents SHALL NOT be assumed valid before the first full clear completes.

Verification (bench parameters: WIDTH=16, ADDR_W=3, DEPTH=8)
REQ-029 Clear: pulse reset for 1 cycle, count edges -> busy stays high for exactly 8 edges, then every address reads 0x0000 with out_valid pulsing once per read.
REQ-030 Write/read: write 0xA5A5 to add=5, then read add=5 -> out=0xA5A5 one edge after the read; out_valid high for exactly 1 cycle, and out holds 0xA5A5 afterward.
REQ-031 Same-cycle read and write: mem[2]=0x1111, then read+write 0x2222 at add=2 -> out=0x1111 when WRITE_FIRST=0 and 0x2222 when WRITE_FIRST=1; a subsequent read returns 0x2222 in both cases.
REQ-032 Gating: write 0xFFFF with en=0, and separately while busy=1 -> the next read returns 0x0000 and out_valid does not pulse during the gated requests.
REQ-033 Reset mid-clear: assert reset at clear edge 4 -> cnt restarts at 0 and busy stays high for 8 more edges; mid-operation reset with data 0xBEEF at add=7 -> out=0 and that address reads 0x0000 after the clear.
REQ-034 Back-to-back reads: read add 0..7 on consecutive cycles after writing value = add*0x0101 -> out streams 0x0000..0x0707 with out_valid continuously high for 8 cycles.
